output_drain_arbiter: RTL and testbench
=======================================

Name: output_drain_arbiter

Overview:
Shares one output result port between NB_LANES parallel convolution controller/MAC lanes. Each lane emits a one-cycle output_valid pulse with its data and (x, y, ch) coordinates. Each lane has a one-entry holding buffer, and the arbiter forwards held results round-robin into a registered valid/ready output stage that feeds the output writer. The block sits between the lane controllers and the external output interface.

Parameters:
NB_LANES, 4, number of requesting lanes (power of two, ≥2)
DATA_WIDTH, 32, result word width
X_WIDTH, 10, output_x width (log2 of feature map width)
Y_WIDTH, 10, output_y width (log2 of feature map height)
CH_WIDTH, 6, output channel width (log2 of output channels)

Ports:
clk  in  1  clock
arst_n_in  in  1  reset, asynchronous, active-low
lane_valid  in  NB_LANES  per-lane result pulse
lane_data  in  NB_LANES*DATA_WIDTH  packed results, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
lane_x  in  NB_LANES*X_WIDTH  packed x coordinates
lane_y  in  NB_LANES*Y_WIDTH  packed y coordinates
lane_ch  in  NB_LANES*CH_WIDTH  packed output channels
lane_ready  out  NB_LANES  lane buffer can accept this cycle
out_valid  out  1  output stage holds a result
out_ready  in  1  consumer accepts
out_data  out  DATA_WIDTH  result
out_x  out  X_WIDTH  coordinate
out_y  out  Y_WIDTH  coordinate
out_ch  out  CH_WIDTH  coordinate
out_lane  out  $clog2(NB_LANES)  source lane
busy  out  1  any buffer or output stage full
clear_err  in  1  clears overflow_err
overflow_err  out  NB_LANES  sticky: result dropped on lane i

Behaviour:
- Reset values: all buffers empty; out_valid=0; out_data/x/y/ch/lane=0; overflow_err=0; rr pointer = NB_LANES-1, so lane 0 has top priority first; busy=0.
- Buffer i: lane_ready[i] = !full[i] || grant[i]. This is combinational and must not depend on lane_valid.
- Write: when lane_valid[i] && lane_ready[i], the entry (data, x, y, ch) is captured and full[i]=1 on the next edge. This applies even when the buffer is being drained in the same cycle (drain and refill simultaneously).
- Drop: when lane_valid[i] && !lane_ready[i], the entry is discarded and overflow_err[i] is set. If clear_err is asserted in the same cycle, set wins.
- Output stage load enable: load = !out_valid || out_ready.
- Grant: when load=1 and any full[i], exactly one grant[i], chosen as the first full lane scanning from pointer+1 upward with wrap-around. No grant when load=0.
- On grant: the output registers take the entry and out_lane=i, out_valid=1, full[i] clears (unless refilled the same cycle), and pointer is set to i.
- When out_valid && out_ready and nothing is granted: out_valid=0. Output data holds its previous value.
- While out_valid && !out_ready: all out_* signals must stay stable.
- Latency: lane pulse at edge t, then out_valid at edge t+1 if the lane is granted in the cycle after t. Minimum 2 edges from pulse to first output cycle.
- Throughput: one result per cycle with out_ready held high.
- Fairness: with all lanes continuously full, each lane is served once every NB_LANES grants.
- busy = out_valid || |full.
- Reset mid-operation: all held results are discarded with no output pulse, and the pointer returns to NB_LANES-1.

Decomposition:
- Shared package conv_pkg: typedef struct packed drain_entry_t {data, x, y, ch}, width localparams, and the lane index typedef.
- Sub-module rr_arbiter (NB_LANES): inputs req, enable; outputs one-hot grant and grant index; owns the pointer register.

Test Plan:
1. Lane 2 pulses once (data=0xA5, x=4, y=8, ch=3), out_ready=1 → 2 edges later out_valid=1 for exactly 1 cycle with 0xA5/4/8/3, out_lane=2; busy drops afterwards.
2. All 4 lanes pulse in the same cycle (data=i), out_ready=1 → out_lane sequence 0,1,2,3 on consecutive cycles; then lanes 1 and 3 pulse → order 1,3 is not required to restart from 0; it is determined by the pointer (pointer=3 → lane 1, then 3).
3. out_ready=0 for 5 cycles with one result held → out_* stable all 5 cycles; out_ready=1 → consumed in 1 cycle.
4. out_ready=0 with output stage full and lane 1 buffered; lane 1 pulses again → lane_ready[1]=0, result dropped, overflow_err=4'b0010; clear_err pulse → 0.
5. Lane 0 pulses on the exact cycle its buffer is granted → no drop; both results appear in order; overflow_err stays 0.
6. Assert arst_n_in low while 3 buffers are full and out_valid=1 → immediately out_valid=0, busy=0, lane_ready=all ones; the first post-reset grant goes to lane 0.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types for the result drain path: the buffered entry layout and the
// lane index type.
package conv_pkg;

    localparam int DRAIN_LANES   = 4;
    localparam int DRAIN_DATA_W  = 32;
    localparam int DRAIN_X_W     = 10;
    localparam int DRAIN_Y_W     = 10;
    localparam int DRAIN_CH_W    = 6;
    localparam int DRAIN_LANE_W  = $clog2(DRAIN_LANES);

    typedef logic [DRAIN_LANE_W-1:0] lane_idx_t;

    typedef struct packed {
        logic [DRAIN_DATA_W-1:0] data;
        logic [DRAIN_X_W-1:0]    x;
        logic [DRAIN_Y_W-1:0]    y;
        logic [DRAIN_CH_W-1:0]   ch;
    } drain_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner,
// wrapping around. The pointer only moves when a grant is issued.
module rr_arbiter #(
    parameter int NB_LANES = 4
) (
    input  logic                        clk,
    input  logic                        arst_n_in,
    input  logic [NB_LANES-1:0]         req,
    input  logic                        enable,
    output logic [NB_LANES-1:0]         grant,
    output logic [$clog2(NB_LANES)-1:0] grant_idx
);

    localparam int IW = $clog2(NB_LANES);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // Offsets 1..NB_LANES; the last offset wraps back onto the pointer itself.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NB_LANES; k++) begin
            cand = ptr_q + IW'(k);
            if (!found && enable && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
        ptr_d = found ? grant_idx : ptr_q;
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            ptr_q <= IW'(NB_LANES - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/output_drain_arbiter.sv
// Collects one-cycle result pulses from parallel lanes into one-entry buffers
// and drains them round-robin into a registered valid/ready output stage.
module output_drain_arbiter
    import conv_pkg::*;
#(
    parameter int NB_LANES   = DRAIN_LANES,
    parameter int DATA_WIDTH = DRAIN_DATA_W,
    parameter int X_WIDTH    = DRAIN_X_W,
    parameter int Y_WIDTH    = DRAIN_Y_W,
    parameter int CH_WIDTH   = DRAIN_CH_W
) (
    input  logic                           clk,
    input  logic                           arst_n_in,
    input  logic [NB_LANES-1:0]            lane_valid,
    input  logic [NB_LANES*DATA_WIDTH-1:0] lane_data,
    input  logic [NB_LANES*X_WIDTH-1:0]    lane_x,
    input  logic [NB_LANES*Y_WIDTH-1:0]    lane_y,
    input  logic [NB_LANES*CH_WIDTH-1:0]   lane_ch,
    output logic [NB_LANES-1:0]            lane_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [X_WIDTH-1:0]             out_x,
    output logic [Y_WIDTH-1:0]             out_y,
    output logic [CH_WIDTH-1:0]            out_ch,
    output logic [$clog2(NB_LANES)-1:0]    out_lane,
    output logic                           busy,
    input  logic                           clear_err,
    output logic [NB_LANES-1:0]            overflow_err
);

    localparam int LW = $clog2(NB_LANES);

    logic [NB_LANES-1:0] full_q;
    logic [NB_LANES-1:0] full_d;
    logic [NB_LANES-1:0] grant;
    logic [NB_LANES-1:0] wr_en;
    logic [NB_LANES-1:0] drop;
    logic [NB_LANES-1:0] err_q;
    logic [NB_LANES-1:0] err_d;
    logic [LW-1:0]       grant_idx;
    logic                load;

    drain_entry_t entry_q    [NB_LANES];
    drain_entry_t lane_entry [NB_LANES];

    drain_entry_t out_q;
    logic         out_valid_q;
    logic [LW-1:0] out_lane_q;

    assign load = !out_valid_q || out_ready;

    rr_arbiter #(
        .NB_LANES (NB_LANES)
    ) u_rr_arbiter (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .req       (full_q),
        .enable    (load),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A buffer being drained this cycle can take a new pulse at the same edge.
    generate
        for (genvar gi = 0; gi < NB_LANES; gi++) begin : g_lane
            assign lane_ready[gi] = !full_q[gi] || grant[gi];
            assign wr_en[gi]      = lane_valid[gi] && lane_ready[gi];
            assign drop[gi]       = lane_valid[gi] && !lane_ready[gi];
            assign full_d[gi]     = wr_en[gi] || (full_q[gi] && !grant[gi]);
            assign lane_entry[gi] = '{
                data: lane_data[gi*DATA_WIDTH +: DATA_WIDTH],
                x:    lane_x[gi*X_WIDTH +: X_WIDTH],
                y:    lane_y[gi*Y_WIDTH +: Y_WIDTH],
                ch:   lane_ch[gi*CH_WIDTH +: CH_WIDTH]
            };
        end
    endgenerate

    // A drop in the same cycle as a clear must survive the clear.
    assign err_d = clear_err ? drop : (err_q | drop);

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_LANES; i++) begin
            if (wr_en[i]) begin
                entry_q[i] <= lane_entry[i];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            full_q      <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_lane_q  <= '0;
        end else begin
            full_q <= full_d;
            err_q  <= err_d;
            if (|grant) begin
                out_valid_q <= 1'b1;
                out_q       <= entry_q[grant_idx];
                out_lane_q  <= grant_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_q.data;
    assign out_x        = out_q.x;
    assign out_y        = out_q.y;
    assign out_ch       = out_q.ch;
    assign out_lane     = out_lane_q;
    assign overflow_err = err_q;
    assign busy         = out_valid_q || (|full_q);

endmodule

// File: tb/tb_output_drain_arbiter.sv
// Bench for output_drain_arbiter: directed pulses, an abstract per-lane slot
// model compared on every cycle, and literal expectations per scenario.
module tb_output_drain_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int XW = 10;
    localparam int YW = 10;
    localparam int CW = 6;

    logic            clk = 1'b0;
    logic            arst_n_in;
    logic [N-1:0]    lane_valid;
    logic [N*DW-1:0] lane_data;
    logic [N*XW-1:0] lane_x;
    logic [N*YW-1:0] lane_y;
    logic [N*CW-1:0] lane_ch;
    logic [N-1:0]    lane_ready;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [XW-1:0]   out_x;
    logic [YW-1:0]   out_y;
    logic [CW-1:0]   out_ch;
    logic [1:0]      out_lane;
    logic            busy;
    logic            clear_err;
    logic [N-1:0]    overflow_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    output_drain_arbiter dut (
        .clk          (clk),
        .arst_n_in    (arst_n_in),
        .lane_valid   (lane_valid),
        .lane_data    (lane_data),
        .lane_x       (lane_x),
        .lane_y       (lane_y),
        .lane_ch      (lane_ch),
        .lane_ready   (lane_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_ch       (out_ch),
        .out_lane     (out_lane),
        .busy         (busy),
        .clear_err    (clear_err),
        .overflow_err (overflow_err)
    );

    // Model: each lane is a slot that is either empty or holds one result.
    bit            m_full [N];
    logic [DW-1:0] m_data [N];
    logic [XW-1:0] m_x    [N];
    logic [YW-1:0] m_y    [N];
    logic [CW-1:0] m_ch   [N];
    int            m_last;
    bit            m_ov;
    logic [DW-1:0] m_odata;
    logic [XW-1:0] m_ox;
    logic [YW-1:0] m_oy;
    logic [CW-1:0] m_och;
    int            m_olane;
    logic [N-1:0]  m_err;
    int            m_pick;
    logic [N-1:0]  m_ready;

    int            seen_lane [$];
    logic [DW-1:0] seen_data [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_full[i] = 0;
            m_data[i] = '0;
            m_x[i]    = '0;
            m_y[i]    = '0;
            m_ch[i]   = '0;
        end
        m_last  = N - 1;
        m_ov    = 0;
        m_odata = '0;
        m_ox    = '0;
        m_oy    = '0;
        m_och   = '0;
        m_olane = 0;
        m_err   = '0;
    endtask

    // Which lane is served this cycle: the next occupied slot after the last winner.
    task automatic model_pick();
        m_pick = -1;
        if (arst_n_in && (!m_ov || out_ready)) begin
            for (int k = 1; k <= N; k++) begin
                if (m_pick < 0 && m_full[(m_last + k) % N]) m_pick = (m_last + k) % N;
            end
        end
        for (int i = 0; i < N; i++) m_ready[i] = !m_full[i] || (m_pick == i);
    endtask

    task automatic model_step();
        logic [N-1:0] drops;
        drops = '0;
        if (!arst_n_in) begin
            model_reset();
            return;
        end
        if (m_pick >= 0) begin
            m_ov    = 1;
            m_odata = m_data[m_pick];
            m_ox    = m_x[m_pick];
            m_oy    = m_y[m_pick];
            m_och   = m_ch[m_pick];
            m_olane = m_pick;
            m_last  = m_pick;
            m_full[m_pick] = 0;
        end else if (out_ready) begin
            m_ov = 0;
        end
        for (int i = 0; i < N; i++) begin
            if (lane_valid[i]) begin
                if (m_ready[i]) begin
                    m_full[i] = 1;
                    m_data[i] = lane_data[i*DW +: DW];
                    m_x[i]    = lane_x[i*XW +: XW];
                    m_y[i]    = lane_y[i*YW +: YW];
                    m_ch[i]   = lane_ch[i*CW +: CW];
                end else begin
                    drops[i] = 1'b1;
                end
            end
        end
        m_err = clear_err ? drops : (m_err | drops);
    endtask

    task automatic cycle();
        bit any_full;
        model_pick();
        @(negedge clk);
        any_full = 0;
        for (int i = 0; i < N; i++) any_full |= m_full[i];
        chk("out_valid", out_valid, m_ov);
        chk("out_data", out_data, m_odata);
        chk("out_x", out_x, m_ox);
        chk("out_y", out_y, m_oy);
        chk("out_ch", out_ch, m_och);
        chk("out_lane", out_lane, m_olane);
        chk("lane_ready", lane_ready, m_ready);
        chk("busy", busy, m_ov || any_full);
        chk("overflow_err", overflow_err, m_err);
        if (out_valid && out_ready) begin
            seen_lane.push_back(int'(out_lane));
            seen_data.push_back(out_data);
        end
        @(posedge clk);
        model_step();
        #1;
        lane_valid = '0;
        clear_err  = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] d, input logic [XW-1:0] x,
                            input logic [YW-1:0] y, input logic [CW-1:0] c);
        lane_valid[i]        = 1'b1;
        lane_data[i*DW +: DW] = d;
        lane_x[i*XW +: XW]    = x;
        lane_y[i*YW +: YW]    = y;
        lane_ch[i*CW +: CW]   = c;
    endtask

    task automatic do_reset();
        arst_n_in = 1'b0;
        #1;
        model_reset();
        cycle();
        arst_n_in = 1'b1;
    endtask

    task automatic chk_seq(input string name, input int exp_lanes[$]);
        chk({name, "_count"}, seen_lane.size(), exp_lanes.size());
        for (int k = 0; k < exp_lanes.size() && k < seen_lane.size(); k++) begin
            chk({name, "_lane"}, seen_lane[k], exp_lanes[k]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        arst_n_in  = 1'b0;
        out_ready  = 1'b1;
        lane_valid = '0;
        lane_data  = '0;
        lane_x     = '0;
        lane_y     = '0;
        lane_ch    = '0;
        clear_err  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_lane_ready", lane_ready, 4'hF);
        chk("rst_overflow", overflow_err, 0);
        arst_n_in = 1'b1;
        cycle();

        // Single pulse on lane 2: output two edges later, for one cycle.
        seen_lane.delete(); seen_data.delete();
        set_lane(2, 32'hA5, 4, 8, 3);
        cycle();
        chk("t1_not_yet", out_valid, 0);
        cycle();
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 32'hA5);
        chk("t1_xyc", {out_x, out_y, out_ch}, {10'd4, 10'd8, 6'd3});
        chk("t1_lane", out_lane, 2);
        cycle();
        chk("t1_valid_end", out_valid, 0);
        chk("t1_busy_end", busy, 0);
        $display("t1 single pulse: out_lanes=%p", seen_lane);

        // All lanes at once from a fresh pointer, then lanes 1 and 3.
        do_reset();
        seen_lane.delete(); seen_data.delete();
        for (int i = 0; i < N; i++) set_lane(i, i, i, i, i);
        repeat (6) cycle();
        chk_seq("t2_all", '{0, 1, 2, 3});
        $display("t2 all lanes: out_lanes=%p", seen_lane);
        seen_lane.delete(); seen_data.delete();
        set_lane(3, 32'h33, 3, 3, 3);
        set_lane(1, 32'h11, 1, 1, 1);
        repeat (5) cycle();
        chk_seq("t2_pair", '{1, 3});
        $display("t2 lanes 1,3: out_lanes=%p", seen_lane);

        // Back-pressure: output held stable for 5 cycles.
        out_ready = 1'b0;
        set_lane(0, 32'h77, 5, 6, 7);
        cycle();
        cycle();
        chk("t3_valid", out_valid, 1);
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_hold_data", out_data, 32'h77);
            chk("t3_hold_lane", out_lane, 0);
        end
        seen_lane.delete(); seen_data.delete();
        out_ready = 1'b1;
        cycle();
        chk_seq("t3_drain", '{0});
        chk("t3_valid_end", out_valid, 0);
        $display("t3 stall: drained lanes=%p", seen_lane);

        // Overflow on lane 1 while output stalled and its buffer full.
        out_ready = 1'b0;
        set_lane(0, 32'h40, 0, 0, 0);
        cycle();
        cycle();
        set_lane(1, 32'h41, 1, 1, 1);
        cycle();
        chk("t4_lane_ready1", lane_ready[1], 0);
        set_lane(1, 32'h42, 2, 2, 2);
        cycle();
        chk("t4_err_set", overflow_err, 4'b0010);
        clear_err = 1'b1;
        cycle();
        chk("t4_err_clr", overflow_err, 0);
        seen_lane.delete(); seen_data.delete();
        out_ready = 1'b1;
        repeat (4) cycle();
        chk_seq("t4_drain", '{0, 1});
        if (seen_data.size() == 2) chk("t4_kept_data", seen_data[1], 32'h41);
        else chk("t4_data_count", seen_data.size(), 2);
        $display("t4 overflow: drained lanes=%p", seen_lane);

        // Refill lane 0 on the exact cycle its buffer is granted.
        seen_lane.delete(); seen_data.delete();
        set_lane(0, 32'h51, 0, 0, 0);
        cycle();
        chk("t5_ready_on_grant", lane_ready[0], 1);
        set_lane(0, 32'h52, 0, 0, 1);
        cycle();
        repeat (4) cycle();
        chk_seq("t5_order", '{0, 0});
        if (seen_data.size() == 2) begin
            chk("t5_first", seen_data[0], 32'h51);
            chk("t5_second", seen_data[1], 32'h52);
        end else begin
            chk("t5_data_count", seen_data.size(), 2);
        end
        chk("t5_no_err", overflow_err, 0);
        $display("t5 refill on grant: data=%p", seen_data);

        // Reset while three buffers and the output stage are occupied.
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) set_lane(i, 32'h60 + i, 0, 0, 0);
        cycle();
        cycle();
        chk("t6_pre_valid", out_valid, 1);
        chk("t6_pre_lane", out_lane, 1);
        arst_n_in = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", lane_ready, 4'hF);
        cycle();
        arst_n_in = 1'b1;
        seen_lane.delete(); seen_data.delete();
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 32'h70 + i, 0, 0, 0);
        repeat (6) cycle();
        chk_seq("t6_post", '{0, 1, 2, 3});
        $display("t6 reset mid-run: post-reset lanes=%p", seen_lane);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
